// File: rtl/mem_line_master_if.sv
// Backup-memory bus seen by the line master: request, write-data and response channels.
// The master drives requests and write data; memory drives the readies and the response beats.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

interface mem_line_master_if #(
  parameter int ADDR_BITS = `MEM_ADDR_BITS,
  parameter int DATA_BITS = `MEM_DATA_BITS,
  parameter int TAG_BITS  = `MEM_TAG_BITS
);
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic                   mem_req_rw;
  logic [ADDR_BITS-1:0]   mem_req_addr;
  logic [TAG_BITS-1:0]    mem_req_tag;
  logic                   mem_req_data_valid;
  logic                   mem_req_data_ready;
  logic [DATA_BITS-1:0]   mem_req_data_bits;
  logic [DATA_BITS/8-1:0] mem_req_data_mask;
  logic [1:0]             mem_req_data_offset;
  logic                   mem_resp_valid;
  logic [DATA_BITS-1:0]   mem_resp_data;
  logic [TAG_BITS-1:0]    mem_resp_tag;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, mem_req_data_offset,
    input  mem_req_ready, mem_req_data_ready,
    input  mem_resp_valid, mem_resp_data, mem_resp_tag
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask, mem_req_data_offset,
    output mem_req_ready, mem_req_data_ready,
    output mem_resp_valid, mem_resp_data, mem_resp_tag
  );
endinterface

// File: rtl/mem_line_master.sv
// Turns whole-line cache commands (read, write, writeback+refill) into per-beat memory
// transactions and assembles 4-beat refills into a line returned to the cache.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 64
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 4
`endif

module mem_line_master #(
  parameter int ADDR_BITS = `MEM_ADDR_BITS,
  parameter int DATA_BITS = `MEM_DATA_BITS,
  parameter int TAG_BITS  = `MEM_TAG_BITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     line_req_valid,
  output logic                     line_req_ready,
  input  logic [1:0]               line_req_op,
  input  logic [ADDR_BITS-3:0]     line_req_addr,
  input  logic [ADDR_BITS-3:0]     line_req_vaddr,
  input  logic [4*DATA_BITS-1:0]   line_req_wdata,
  input  logic [4*DATA_BITS/8-1:0] line_req_wmask,
  output logic                     line_resp_valid,
  output logic [4*DATA_BITS-1:0]   line_resp_data,
  mem_line_master_if.master        mem
);
  localparam int MASK_BITS = DATA_BITS / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_RESP, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       is_wb_q;
  logic [ADDR_BITS-3:0]       line_q;
  logic [ADDR_BITS-3:0]       wline_q;
  logic [4*DATA_BITS-1:0]     wdata_q;
  logic [4*MASK_BITS-1:0]     wmask_q;
  logic [1:0]                 beat_q;
  logic [1:0]                 cnt_q;
  logic [TAG_BITS-1:0]        tag_q;
  logic [4*DATA_BITS-1:0]     line_data_q;

  logic                       is_write_op;
  logic                       is_wb_op;
  logic [2:0]                 first_beat;
  logic [2:0]                 next_beat;
  logic                       resp_hit;

  // Lowest beat at or above start with a non-zero byte mask; 4 means none left.
  function automatic logic [2:0] find_beat(input logic [4*MASK_BITS-1:0] m, input logic [2:0] start);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (3'(i) >= start && |m[i*MASK_BITS +: MASK_BITS]) r = 3'(i);
    end
    return r;
  endfunction

  assign is_wb_op    = (line_req_op == 2'd2);
  assign is_write_op = (line_req_op == 2'd1) || is_wb_op;
  assign first_beat  = find_beat(line_req_wmask, 3'd0);
  assign next_beat   = find_beat(wmask_q, {1'b0, beat_q} + 3'd1);
  assign resp_hit    = (state_q == RD_RESP) && mem.mem_resp_valid && (mem.mem_resp_tag == tag_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    line_req_ready          = 1'b0;
    line_resp_valid         = 1'b0;
    mem.mem_req_valid       = 1'b0;
    mem.mem_req_rw          = 1'b0;
    mem.mem_req_addr        = '0;
    mem.mem_req_tag         = tag_q;
    mem.mem_req_data_valid  = 1'b0;
    mem.mem_req_data_bits   = wdata_q[beat_q*DATA_BITS +: DATA_BITS];
    mem.mem_req_data_mask   = wmask_q[beat_q*MASK_BITS +: MASK_BITS];
    mem.mem_req_data_offset = beat_q;
    case (state_q)
      IDLE: begin
        line_req_ready = 1'b1;
        if (line_req_valid) begin
          if (!is_write_op)        state_d = RD_REQ;
          else if (!first_beat[2]) state_d = WR_REQ;
          else if (is_wb_op)       state_d = RD_REQ;
          else                     state_d = DONE;
        end
      end
      WR_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_rw    = 1'b1;
        mem.mem_req_addr  = {wline_q, beat_q};
        if (mem.mem_req_ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        mem.mem_req_data_valid = 1'b1;
        if (mem.mem_req_data_ready) begin
          if (!next_beat[2]) state_d = WR_REQ;
          else if (is_wb_q)  state_d = RD_REQ;
          else               state_d = DONE;
        end
      end
      RD_REQ: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_req_addr  = {line_q, 2'b00};
        if (mem.mem_req_ready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (resp_hit && cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        line_resp_valid = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The write line is kept whole so skipped beats need no special storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_wb_q     <= 1'b0;
      line_q      <= '0;
      wline_q     <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      beat_q      <= 2'd0;
      cnt_q       <= 2'd0;
      tag_q       <= '0;
      line_data_q <= '0;
    end else begin
      if (state_q == IDLE && line_req_valid) begin
        is_wb_q <= is_wb_op;
        line_q  <= line_req_addr;
        wline_q <= is_wb_op ? line_req_vaddr : line_req_addr;
        wdata_q <= line_req_wdata;
        wmask_q <= line_req_wmask;
        beat_q  <= first_beat[1:0];
      end
      if (state_q == WR_DATA && mem.mem_req_data_ready && !next_beat[2])
        beat_q <= next_beat[1:0];
      if (state_q == RD_REQ && mem.mem_req_ready)
        cnt_q <= 2'd0;
      if (resp_hit) begin
        line_data_q[cnt_q*DATA_BITS +: DATA_BITS] <= mem.mem_resp_data;
        cnt_q <= cnt_q + 2'd1;
        if (cnt_q == 2'd3) tag_q <= tag_q + TAG_BITS'(1);
      end
    end
  end

  assign line_resp_data = line_data_q;
endmodule

// File: tb/tb_mem_line_master.sv
// Self-checking bench for mem_line_master: a memory model answers the bus while a reference
// memory and scoreboard queues predict every request, write beat and returned line.
module tb_mem_line_master;
  localparam int ADDR_BITS  = 8;
  localparam int DATA_BITS  = 32;
  localparam int TAG_BITS   = 2;
  localparam int MASK_BITS  = DATA_BITS / 8;
  localparam int LADDR_BITS = ADDR_BITS - 2;
  localparam int MEM_WORDS  = 1 << ADDR_BITS;

  typedef struct packed {
    logic                 rw;
    logic [ADDR_BITS-1:0] addr;
    logic [TAG_BITS-1:0]  tag;
    logic                 chk_tag;
  } req_t;
  typedef struct packed {
    logic [DATA_BITS-1:0] bits;
    logic [MASK_BITS-1:0] mask;
    logic [1:0]           offset;
  } wd_t;
  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [DATA_BITS-1:0] data;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     line_req_valid = 1'b0;
  logic                     line_req_ready;
  logic [1:0]               line_req_op = 2'd0;
  logic [LADDR_BITS-1:0]    line_req_addr = '0;
  logic [LADDR_BITS-1:0]    line_req_vaddr = '0;
  logic [4*DATA_BITS-1:0]   line_req_wdata = '0;
  logic [4*MASK_BITS-1:0]   line_req_wmask = '0;
  logic                     line_resp_valid;
  logic [4*DATA_BITS-1:0]   line_resp_data;

  logic stall_en = 1'b0;
  logic inject_stale = 1'b0;

  int total = 0;
  int bad = 0;

  req_t                   exp_req[$];
  wd_t                    exp_wd[$];
  logic [4*DATA_BITS-1:0] exp_line[$];
  logic [DATA_BITS-1:0]   ref_mem [0:MEM_WORDS-1];
  logic [TAG_BITS-1:0]    tb_tag = '0;
  logic [4*DATA_BITS-1:0] last_line = '0;

  always #5 clk = ~clk;

  mem_line_master_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS)) mem_bus ();

  mem_line_master #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .TAG_BITS(TAG_BITS)) dut (
    .clk            (clk),
    .reset          (reset),
    .line_req_valid (line_req_valid),
    .line_req_ready (line_req_ready),
    .line_req_op    (line_req_op),
    .line_req_addr  (line_req_addr),
    .line_req_vaddr (line_req_vaddr),
    .line_req_wdata (line_req_wdata),
    .line_req_wmask (line_req_wmask),
    .line_resp_valid(line_resp_valid),
    .line_resp_data (line_resp_data),
    .mem            (mem_bus.master)
  );

  function automatic logic [DATA_BITS-1:0] init_word(input int a);
    return DATA_BITS'(32'h5A00_0000 + a * 32'h0001_0003);
  endfunction

  // Memory model: read requests queue 4 tagged beats that stream back one per cycle.
  logic [DATA_BITS-1:0] mem_array [0:MEM_WORDS-1];
  beat_t                resp_q[$];
  logic                 mem_inited = 1'b0;
  logic [ADDR_BITS-1:0] wr_addr_pend = '0;

  always @(posedge clk) begin
    beat_t               bt;
    logic [TAG_BITS-1:0] stale_tag;
    if (!mem_inited) begin
      for (int a = 0; a < MEM_WORDS; a++) mem_array[a] = init_word(a);
      mem_inited = 1'b1;
    end
    if (mem_bus.mem_req_valid === 1'b1 && mem_bus.mem_req_ready === 1'b1) begin
      if (mem_bus.mem_req_rw) begin
        wr_addr_pend = mem_bus.mem_req_addr;
      end else begin
        if (inject_stale) begin
          stale_tag = mem_bus.mem_req_tag + TAG_BITS'(1);
          bt.tag  = stale_tag;
          bt.data = DATA_BITS'(32'hDEAD_BEEF);
          resp_q.push_back(bt);
        end
        for (int b = 0; b < 4; b++) begin
          bt.tag  = mem_bus.mem_req_tag;
          bt.data = mem_array[{mem_bus.mem_req_addr[ADDR_BITS-1:2], 2'(b)}];
          resp_q.push_back(bt);
        end
      end
    end
    if (mem_bus.mem_req_data_valid === 1'b1 && mem_bus.mem_req_data_ready === 1'b1) begin
      for (int k = 0; k < MASK_BITS; k++)
        if (mem_bus.mem_req_data_mask[k]) mem_array[wr_addr_pend][k*8 +: 8] = mem_bus.mem_req_data_bits[k*8 +: 8];
    end
    if (resp_q.size() > 0) begin
      bt = resp_q.pop_front();
      mem_bus.mem_resp_valid <= 1'b1;
      mem_bus.mem_resp_data  <= bt.data;
      mem_bus.mem_resp_tag   <= bt.tag;
    end else begin
      mem_bus.mem_resp_valid <= 1'b0;
      mem_bus.mem_resp_data  <= '0;
      mem_bus.mem_resp_tag   <= '0;
    end
    mem_bus.mem_req_ready      <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    mem_bus.mem_req_data_ready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Pushes the predicted bus traffic and line for one command, issues it, then drains the
  // scoreboard as the DUT produces requests, write beats and its completion pulse.
  task automatic do_cmd(input logic [1:0] op, input logic [LADDR_BITS-1:0] addr,
                        input logic [LADDR_BITS-1:0] vaddr, input logic [4*DATA_BITS-1:0] wdata,
                        input logic [4*MASK_BITS-1:0] wmask, input int budget, output int cycles);
    req_t                   r;
    wd_t                    w;
    logic [LADDR_BITS-1:0]  wline;
    logic [4*DATA_BITS-1:0] line;
    logic [ADDR_BITS-1:0]   wa;
    int                     waited;
    logic                   done;
    if (op == 2'd1 || op == 2'd2) begin
      wline = (op == 2'd2) ? vaddr : addr;
      for (int b = 0; b < 4; b++) begin
        if (|wmask[b*MASK_BITS +: MASK_BITS]) begin
          r.rw = 1'b1; r.addr = {wline, 2'(b)}; r.tag = '0; r.chk_tag = 1'b0;
          exp_req.push_back(r);
          w.bits = wdata[b*DATA_BITS +: DATA_BITS]; w.mask = wmask[b*MASK_BITS +: MASK_BITS]; w.offset = 2'(b);
          exp_wd.push_back(w);
          wa = {wline, 2'(b)};
          for (int k = 0; k < MASK_BITS; k++)
            if (w.mask[k]) ref_mem[wa][k*8 +: 8] = w.bits[k*8 +: 8];
        end
      end
    end
    if (op != 2'd1) begin
      r.rw = 1'b0; r.addr = {addr, 2'b00}; r.tag = tb_tag; r.chk_tag = 1'b1;
      exp_req.push_back(r);
      for (int b = 0; b < 4; b++) line[b*DATA_BITS +: DATA_BITS] = ref_mem[{addr, 2'(b)}];
      last_line = line;
      tb_tag = tb_tag + TAG_BITS'(1);
    end
    exp_line.push_back(last_line);

    waited = 0;
    @(negedge clk);
    while (line_req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (line_req_ready !== 1'b1) begin
      bad++;
      $display("[TB] FAIL accept_wait: line_req_ready=%b, required 1", line_req_ready);
    end
    line_req_valid = 1'b1; line_req_op = op; line_req_addr = addr; line_req_vaddr = vaddr;
    line_req_wdata = wdata; line_req_wmask = wmask;
    @(posedge clk);
    #1 line_req_valid = 1'b0;

    cycles = 0;
    done = 1'b0;
    while (!done && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        total++;
        if (line_req_ready !== 1'b0) begin
          bad++;
          $display("[TB] FAIL busy_ready: line_req_ready=%b, required 0", line_req_ready);
        end
      end
      total++;
      if (mem_bus.mem_req_valid === 1'b1 && mem_bus.mem_req_data_valid === 1'b1) begin
        bad++;
        $display("[TB] FAIL one_valid: req_valid=1 data_valid=1, required at most one");
      end
      if (mem_bus.mem_req_valid === 1'b1 && mem_bus.mem_req_ready === 1'b1) begin
        total++;
        if (exp_req.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_req: got addr=%h rw=%b, required no request", mem_bus.mem_req_addr, mem_bus.mem_req_rw);
        end else begin
          r = exp_req.pop_front();
          if (mem_bus.mem_req_rw !== r.rw || mem_bus.mem_req_addr !== r.addr ||
              (r.chk_tag && mem_bus.mem_req_tag !== r.tag)) begin
            bad++;
            $display("[TB] FAIL req: got rw=%b addr=%h tag=%0d, required rw=%b addr=%h tag=%0d",
                     mem_bus.mem_req_rw, mem_bus.mem_req_addr, mem_bus.mem_req_tag, r.rw, r.addr, r.tag);
          end
        end
      end
      if (mem_bus.mem_req_data_valid === 1'b1 && mem_bus.mem_req_data_ready === 1'b1) begin
        total++;
        if (exp_wd.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_wdata: got bits=%h, required no data beat", mem_bus.mem_req_data_bits);
        end else begin
          w = exp_wd.pop_front();
          if (mem_bus.mem_req_data_bits !== w.bits || mem_bus.mem_req_data_mask !== w.mask ||
              mem_bus.mem_req_data_offset !== w.offset) begin
            bad++;
            $display("[TB] FAIL wdata: got bits=%h mask=%b off=%0d, required bits=%h mask=%b off=%0d",
                     mem_bus.mem_req_data_bits, mem_bus.mem_req_data_mask, mem_bus.mem_req_data_offset,
                     w.bits, w.mask, w.offset);
          end
        end
      end
      if (line_resp_valid === 1'b1) begin
        done = 1'b1;
        total++;
        if (exp_line.size() == 0) begin
          bad++;
          $display("[TB] FAIL extra_resp: got line_resp_valid=1, required none");
        end else begin
          line = exp_line.pop_front();
          if (line_resp_data !== line) begin
            bad++;
            $display("[TB] FAIL line_data: got %h, required %h", line_resp_data, line);
          end
        end
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL timeout: no line_resp_valid within %0d cycles, required completion", budget);
    end
    total++;
    if (exp_req.size() != 0 || exp_wd.size() != 0) begin
      bad++;
      $display("[TB] FAIL missing_traffic: %0d requests and %0d data beats outstanding, required 0",
               exp_req.size(), exp_wd.size());
    end
    exp_req.delete();
    exp_wd.delete();
    exp_line.delete();
    if (done) begin
      @(negedge clk);
      total++;
      if (line_resp_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL resp_pulse: line_resp_valid=%b one cycle later, required 0", line_resp_valid);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (line_req_ready !== 1'b1 || mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_req_data_valid !== 1'b0 ||
        line_resp_valid !== 1'b0 || line_resp_data !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: ready=%b req_v=%b data_v=%b resp_v=%b data=%h, required 1 0 0 0 0",
               line_req_ready, mem_bus.mem_req_valid, mem_bus.mem_req_data_valid, line_resp_valid, line_resp_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    int cyc;
    do_cmd(2'd0, 6'h10, 6'h00, '0, '0, 20, cyc);
    total++;
    if (cyc !== 6) begin
      bad++;
      $display("[TB] FAIL read_latency: got %0d cycles, required 6", cyc);
    end
  endtask

  task automatic test_write_full();
    int cyc;
    logic [4*DATA_BITS-1:0] wd;
    wd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
    do_cmd(2'd1, 6'h08, 6'h00, wd, '1, 40, cyc);
    total++;
    if (cyc !== 9) begin
      bad++;
      $display("[TB] FAIL write_latency: got %0d cycles, required 9", cyc);
    end
    do_cmd(2'd0, 6'h08, 6'h00, '0, '0, 20, cyc);
    total++;
    if (line_resp_data !== wd) begin
      bad++;
      $display("[TB] FAIL write_readback: got %h, required %h", line_resp_data, wd);
    end
  endtask

  task automatic test_write_sparse();
    int cyc;
    do_cmd(2'd1, 6'h09, 6'h00, {4{32'h1234_5678}}, 16'h0500, 20, cyc);
    total++;
    if (cyc !== 3) begin
      bad++;
      $display("[TB] FAIL sparse_latency: got %0d cycles, required 3", cyc);
    end
    do_cmd(2'd0, 6'h09, 6'h00, '0, '0, 20, cyc);
    do_cmd(2'd1, 6'h0A, 6'h00, {4{32'hFFFF_FFFF}}, '0, 20, cyc);
    total++;
    if (cyc !== 1) begin
      bad++;
      $display("[TB] FAIL zero_mask_latency: got %0d cycles, required 1", cyc);
    end
  endtask

  task automatic test_wb_refill();
    int cyc;
    logic [4*DATA_BITS-1:0] wd;
    wd = {32'h0303_0004, 32'h0303_0003, 32'h0303_0002, 32'h0303_0001};
    do_cmd(2'd2, 6'h07, 6'h03, wd, '1, 40, cyc);
    total++;
    if (cyc !== 14) begin
      bad++;
      $display("[TB] FAIL wb_latency: got %0d cycles, required 14", cyc);
    end
    do_cmd(2'd0, 6'h03, 6'h00, '0, '0, 20, cyc);
    total++;
    if (line_resp_data !== wd) begin
      bad++;
      $display("[TB] FAIL victim_readback: got %h, required %h", line_resp_data, wd);
    end
    do_cmd(2'd2, 6'h0B, 6'h04, '1, '0, 20, cyc);
    total++;
    if (cyc !== 6) begin
      bad++;
      $display("[TB] FAIL wb_zero_mask_latency: got %0d cycles, required 6", cyc);
    end
  endtask

  task automatic test_stale();
    int cyc;
    inject_stale = 1'b1;
    do_cmd(2'd0, 6'h05, 6'h00, '0, '0, 20, cyc);
    inject_stale = 1'b0;
    total++;
    if (cyc !== 7) begin
      bad++;
      $display("[TB] FAIL stale_latency: got %0d cycles, required 7", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [1:0]             op;
    logic [4*DATA_BITS-1:0] wd;
    logic [4*MASK_BITS-1:0] wm;
    stall_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      for (int b = 0; b < 4; b++) begin
        wd[b*DATA_BITS +: DATA_BITS] = $urandom;
        wm[b*MASK_BITS +: MASK_BITS] = ($urandom_range(0, 3) == 0) ? '0 : MASK_BITS'($urandom);
      end
      do_cmd(op, LADDR_BITS'($urandom), LADDR_BITS'($urandom), wd, wm, 300, cyc);
    end
    stall_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    @(negedge clk);
    line_req_valid = 1'b1; line_req_op = 2'd0; line_req_addr = 6'h11;
    @(posedge clk);
    #1 line_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (mem_bus.mem_req_valid !== 1'b0 || mem_bus.mem_req_data_valid !== 1'b0 || line_resp_valid !== 1'b0 ||
        line_req_ready !== 1'b1 || line_resp_data !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: req_v=%b data_v=%b resp_v=%b ready=%b data=%h, required 0 0 0 1 0",
               mem_bus.mem_req_valid, mem_bus.mem_req_data_valid, line_resp_valid, line_req_ready, line_resp_data);
    end
    @(negedge clk);
    reset = 1'b0;
    tb_tag = '0;
    last_line = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (line_resp_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL aborted_resp: line_resp_valid=1 after reset, required 0");
      end
    end
    total++;
    if (line_resp_data !== '0) begin
      bad++;
      $display("[TB] FAIL late_beats: line_resp_data=%h, required 0", line_resp_data);
    end
    do_cmd(2'd0, 6'h12, 6'h00, '0, '0, 20, cyc);
    total++;
    if (cyc !== 6) begin
      bad++;
      $display("[TB] FAIL post_reset_latency: got %0d cycles, required 6", cyc);
    end
  endtask

  initial begin
    for (int a = 0; a < MEM_WORDS; a++) ref_mem[a] = init_word(a);
    test_reset();
    test_read();
    test_write_full();
    test_write_sparse();
    test_wb_refill();
    test_stale();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
